uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of the SoC's fixed 8N1 receive path. It adds configurable data width, optional parity, one or two stop bits, and an input synchroniser. It also adds false-start rejection, parity/framing error flags and break recovery. It sits between the UART pin and the UART peripheral's RX FIFO/register interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB received first
SYNC_STAGES, 2, flops in the i_UART_RX synchroniser; legal 2..4

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_ClksPerBit  in  16  bit period minus one, in clocks; legal >= 4
i_ParityEn  in  1  1 = parity bit follows data
i_ParityOdd  in  1  1 = odd parity, 0 = even; ignored if i_ParityEn = 0
i_StopBits2  in  1  1 = two stop bits, 0 = one
i_UART_RX  in  1  asynchronous serial input, idle high
o_RxDataValid  out  1  one-cycle pulse: frame complete
o_RxData  out  DATA_BITS  received data; held until next frame
o_ParityErr  out  1  parity mismatch for the frame; updates with o_RxDataValid
o_FrameErr  out  1  a stop bit sampled low; updates with o_RxDataValid

Behaviour:
- Clocking: one clock domain, i_Clk. Reset is synchronous and active-high on i_Reset.
- Reset values:
  - o_RxDataValid = 0, o_RxData = 0, o_ParityErr = 0, o_FrameErr = 0.
  - Synchroniser flops = 1, state = IDLE, all counters = 0.
- Reset mid-frame: the partial frame is discarded with no valid pulse.
- Config latch: i_ClksPerBit, i_ParityEn, i_ParityOdd and i_StopBits2 are latched on start detection. Changes during a frame have no effect until the next frame.
- Timing: bit period = i_ClksPerBit+1 clocks. The bit counter runs 0..ClksPerBit, then wraps to 0. The half-bit wait runs 0..ClksPerBit>>1.
- States:
  - IDLE: synchronised RX = 0 -> START; counter cleared.
  - START: at counter == ClksPerBit>>1, sample the line.
    - 1 -> IDLE (false start; no pulse, flags unchanged).
    - 0 -> DATA; counter cleared.
  - DATA: at counter == ClksPerBit, sample a bit and shift it in LSB-first. After DATA_BITS samples -> PARITY if enabled, else STOP1.
  - PARITY: sample the parity bit at full period. Error = XOR(data, parity bit) != i_ParityOdd.
  - STOP1: sample at full period.
    - If two stop bits are configured -> STOP2; a low sample is recorded as a framing error.
    - Otherwise the frame completes.
  - STOP2: sample at full period; the frame completes.
  - BREAK_WAIT: wait until synchronised RX = 1, then -> IDLE.
- Frame completion:
  - In the cycle after the final stop sample: o_RxDataValid = 1 for exactly one cycle.
  - o_RxData, o_ParityErr and o_FrameErr update in that same cycle.
  - Next state is IDLE if the final stop sample was 1, else BREAK_WAIT. A held-low line never re-triggers START.
- Start detection: back-to-back frames are supported. Start detection resumes from mid-stop-bit.
- Latency: pin to synchronised line = SYNC_STAGES clocks.
- Data register: DATA_BITS wide, no unused bits.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each data, parity and stop bit is decided by a 2-of-3 majority of samples at counter == ClksPerBit-2, ClksPerBit-1 and ClksPerBit.
  - The decision is taken at ClksPerBit.
  - The START check uses the same vote around ClksPerBit>>1.
- Undefined: single sample at the decision point. No extra flops are present.

Decomposition:
- Package uart_pkg: state encoding constants (IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT) and the DATA_BITS legal-range limits.
- Sub-module uart_sync: SYNC_STAGES-deep synchroniser, reset to 1. It is reused by the future transmitter's CTS input.

Test Plan:
- ClksPerBit=15, 8N1, send 0xA5 -> one pulse, o_RxData=0xA5, both error flags 0. Pulse occurs exactly 1+SYNC_STAGES clocks after the centre of the stop bit.
- Even parity enabled, send 0x3C with parity bit 1 (wrong) -> o_RxData=0x3C, o_ParityErr=1. Then a correct frame 0x3C with parity 0 -> o_ParityErr=0.
- 4-clock low glitch on idle line (ClksPerBit=15) -> no pulse. State returns to IDLE; a following 0x5A is received correctly.
- Send 0x00 with stop bit low, then hold low for 40 bit times -> single pulse with o_FrameErr=1. No further pulses until the line rises; the next 0x81 is received cleanly.
- i_StopBits2=1, three back-to-back frames 0x11, 0x22, 0x33 with no idle gap -> three pulses, data in order, no errors. A second stop bit driven low instead -> o_FrameErr=1.
- DATA_BITS=7 instance, send 0x55 -> o_RxData=7'h55. Assert i_Reset mid-DATA -> no pulse, outputs 0. The next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receive path: FSM state encoding,
// DATA_BITS legal range and the majority-vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP1      = 3'd4,
    STOP2      = 3'd5,
    BREAK_WAIT = 3'd6
  } uart_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

endpackage

// File: rtl/uart_sync.sv
// SYNC_STAGES-deep flop chain bringing an idle-high asynchronous line into i_Clk.
// Resets to 1 so a freshly reset receiver never sees a phantom start bit.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_Async};
    end
  end

  assign o_Sync = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, one/two stop bits, break recovery.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over the last three clocks.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic [15:0]          i_ClksPerBit,
  input  logic                 i_ParityEn,
  input  logic                 i_ParityOdd,
  input  logic                 i_StopBits2,
  input  logic                 i_UART_RX,
  output logic                 o_RxDataValid,
  output logic [DATA_BITS-1:0] o_RxData,
  output logic                 o_ParityErr,
  output logic                 o_FrameErr
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS_MAX + 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
    $error("uart_rx_cfg: DATA_BITS out of range");
  end

  logic                 rx_sync;
  uart_state_t          state_reg;
  logic [15:0]          cnt_reg;
  logic [15:0]          cpb_reg;
  logic                 par_en_reg;
  logic                 par_odd_reg;
  logic                 stop2_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_reg;
  logic                 frm_err_reg;

  logic [15:0]          half_period;
  logic [15:0]          target;
  logic                 at_target;
  logic                 bit_val;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_Async(i_UART_RX),
    .o_Sync (rx_sync)
  );

  // START decides at half a bit; every later bit decides at the full period.
  assign half_period = cpb_reg >> 1;
  assign target      = (state_reg == START) ? half_period : cpb_reg;
  assign at_target   = (cnt_reg == target);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_reg;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vote_reg <= 2'b11;
    end else begin
      if (cnt_reg == target - 16'd2) vote_reg[0] <= rx_sync;
      if (cnt_reg == target - 16'd1) vote_reg[1] <= rx_sync;
    end
  end

  assign bit_val = maj3(vote_reg[0], vote_reg[1], rx_sync);
`else
  assign bit_val = rx_sync;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cpb_reg       <= '0;
      par_en_reg    <= 1'b0;
      par_odd_reg   <= 1'b0;
      stop2_reg     <= 1'b0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      par_err_reg   <= 1'b0;
      frm_err_reg   <= 1'b0;
      o_RxDataValid <= 1'b0;
      o_RxData      <= '0;
      o_ParityErr   <= 1'b0;
      o_FrameErr    <= 1'b0;
    end else begin
      o_RxDataValid <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rx_sync) begin
            cpb_reg     <= i_ClksPerBit;
            par_en_reg  <= i_ParityEn;
            par_odd_reg <= i_ParityOdd;
            stop2_reg   <= i_StopBits2;
            state_reg   <= START;
          end
        end
        START: begin
          if (at_target) begin
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
            state_reg   <= bit_val ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        DATA: begin
          if (at_target) begin
            cnt_reg   <= '0;
            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == BIT_CNT_W'(DATA_BITS - 1)) begin
              state_reg <= par_en_reg ? PARITY : STOP1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        PARITY: begin
          if (at_target) begin
            cnt_reg     <= '0;
            par_err_reg <= ((^shift_reg) ^ bit_val) != par_odd_reg;
            state_reg   <= STOP1;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        STOP1, STOP2: begin
          if (at_target) begin
            cnt_reg <= '0;
            if (state_reg == STOP1 && stop2_reg) begin
              frm_err_reg <= frm_err_reg | ~bit_val;
              state_reg   <= STOP2;
            end else begin
              // A low final stop means the line may be in break; wait for it to rise.
              o_RxDataValid <= 1'b1;
              o_RxData      <= shift_reg;
              o_ParityErr   <= par_err_reg;
              o_FrameErr    <= frm_err_reg | ~bit_val;
              state_reg     <= bit_val ? IDLE : BREAK_WAIT;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        BREAK_WAIT: begin
          cnt_reg <= '0;
          if (rx_sync) state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised bench for uart_rx_cfg: frames are built bit-by-bit from the frame format and
// expected data, flags and pulse time are predicted from that format alone.
module tb_uart_rx_cfg;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpb_in = 16'd15;
  logic        pen_in = 1'b0;
  logic        podd_in = 1'b0;
  logic        s2_in = 1'b0;
  logic        rx8 = 1'b1;
  logic        rx7 = 1'b1;

  logic        v8, pe8, fe8;
  logic [7:0]  d8;
  logic        v7, pe7, fe7;
  logic [6:0]  d7;

  int n_run = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  typedef struct packed {
    logic [31:0] at;
    logic        unit;
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t g, e;

  uart_rx_cfg #(.DATA_BITS(8), .SYNC_STAGES(SYNC)) dut8 (
    .i_Clk(clk), .i_Reset(rst), .i_ClksPerBit(cpb_in), .i_ParityEn(pen_in),
    .i_ParityOdd(podd_in), .i_StopBits2(s2_in), .i_UART_RX(rx8),
    .o_RxDataValid(v8), .o_RxData(d8), .o_ParityErr(pe8), .o_FrameErr(fe8)
  );

  uart_rx_cfg #(.DATA_BITS(7), .SYNC_STAGES(SYNC)) dut7 (
    .i_Clk(clk), .i_Reset(rst), .i_ClksPerBit(cpb_in), .i_ParityEn(pen_in),
    .i_ParityOdd(podd_in), .i_StopBits2(s2_in), .i_UART_RX(rx7),
    .o_RxDataValid(v7), .o_RxData(d7), .o_ParityErr(pe7), .o_FrameErr(fe7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Record every pulse with the index of the clock edge that raised it.
  always @(negedge clk) begin
    if (v8) got_q.push_back('{at: 32'(edge_cnt), unit: 1'b0, data: {1'b0, d8}, perr: pe8, ferr: fe8});
    if (v7) got_q.push_back('{at: 32'(edge_cnt), unit: 1'b1, data: {2'b00, d7}, perr: pe7, ferr: fe7});
  end

  task automatic cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int unit, input logic b);
    if (unit == 1) rx7 = b;
    else rx8 = b;
  endtask

  // Sends one frame and queues its predicted result. Config inputs are scrambled once the
  // start bit is out, so only the values presented at the start edge may matter.
  task automatic send_frame(input int unit, input int db, input logic [8:0] data, input int cpb,
                            input bit pen, input bit podd, input bit pflip, input bit s2,
                            input bit s1v, input bit s2v);
    logic [8:0] d;
    bit         bits[$];
    bit         pbit;
    int         ones;
    int         last;
    rec_t       r;
    d    = data & ((9'h1 << db) - 9'h1);
    ones = $countones(d);
    pbit = bit'((ones % 2) != int'(podd)) ^ pflip;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(s1v);
    if (s2) bits.push_back(s2v);
    last   = bits.size() - 1;
    r.at   = 32'(edge_cnt + 1 + last * (cpb + 1) + (cpb >> 1) + SYNC + 1);
    r.unit = (unit == 1);
    r.data = d;
    r.perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
    r.ferr = !s1v || (s2 && !s2v);
    exp_q.push_back(r);
    cpb_in  = 16'(cpb);
    pen_in  = pen;
    podd_in = podd;
    s2_in   = s2;
    foreach (bits[i]) begin
      drive(unit, bits[i]);
      cycles(cpb + 1);
      if (i == 0) begin
        cpb_in  = 16'($urandom_range(4, 40));
        pen_in  = 1'($urandom);
        podd_in = 1'($urandom);
        s2_in   = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(4);
    rst = 1'b0;
    cycles(2);
    n_run += 8;
    if (v8 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid8: got %b need 0", v8); end
    if (d8 !== 8'h00)  begin n_fail++; $display("FAIL reset_data8: got %h need 00", d8); end
    if (pe8 !== 1'b0)  begin n_fail++; $display("FAIL reset_perr8: got %b need 0", pe8); end
    if (fe8 !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr8: got %b need 0", fe8); end
    if (v7 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid7: got %b need 0", v7); end
    if (d7 !== 7'h00)  begin n_fail++; $display("FAIL reset_data7: got %h need 00", d7); end
    if (pe7 !== 1'b0)  begin n_fail++; $display("FAIL reset_perr7: got %b need 0", pe7); end
    if (fe7 !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr7: got %b need 0", fe7); end
    $display("[TB] reset: outputs v8=%b d8=%h v7=%b d7=%h", v8, d8, v7, d7);
  endtask

  task automatic test_basic_8n1();
    send_frame(0, 8, 9'h0A5, 15, 0, 0, 0, 0, 1, 1);
    cycles(40);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] basic: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL basic_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
    send_frame(0, 8, 9'h03C, 15, 1, 0, 1, 0, 1, 1);
    send_frame(0, 8, 9'h03C, 15, 1, 0, 0, 0, 1, 1);
    send_frame(0, 8, 9'($urandom), 11, 1, 1, 0, 0, 1, 1);
    send_frame(0, 8, 9'($urandom), 11, 1, 1, 1, 0, 1, 1);
    cycles(40);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL parity_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] parity: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL parity_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    cpb_in = 16'd15; pen_in = 1'b0; s2_in = 1'b0;
    rx8 = 1'b0;
    cycles(4);
    rx8 = 1'b1;
    cycles(48);
    send_frame(0, 8, 9'h05A, 15, 0, 0, 0, 0, 1, 1);
    cycles(40);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL glitch_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] glitch: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL glitch_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_break();
    send_frame(0, 8, 9'h000, 15, 0, 0, 0, 0, 0, 1);
    cycles(40 * 16);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL break_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] break: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL break_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
    rx8 = 1'b1;
    cycles(32);
    send_frame(0, 8, 9'h081, 15, 0, 0, 0, 0, 1, 1);
    cycles(40);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL break_recover_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] break_recover: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL break_recover_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8, 9'h011, 15, 0, 0, 0, 1, 1, 1);
    send_frame(0, 8, 9'h022, 15, 0, 0, 0, 1, 1, 1);
    send_frame(0, 8, 9'h033, 15, 0, 0, 0, 1, 1, 1);
    send_frame(0, 8, 9'h044, 15, 0, 0, 0, 1, 1, 0);
    rx8 = 1'b1;
    cycles(40);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] b2b: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL b2b_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_width7();
    send_frame(1, 7, 9'h055, 15, 0, 0, 0, 0, 1, 1);
    cycles(40);
    // Abort a frame three data bits in.
    cpb_in = 16'd15; pen_in = 1'b0; s2_in = 1'b0;
    rx7 = 1'b0; cycles(16);
    rx7 = 1'b1; cycles(16);
    rx7 = 1'b0; cycles(16);
    rx7 = 1'b1; cycles(16);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    n_run += 4;
    if (v7 !== 1'b0)  begin n_fail++; $display("FAIL w7_rst_valid: got %b need 0", v7); end
    if (d7 !== 7'h00) begin n_fail++; $display("FAIL w7_rst_data: got %h need 00", d7); end
    if (pe7 !== 1'b0) begin n_fail++; $display("FAIL w7_rst_perr: got %b need 0", pe7); end
    if (fe7 !== 1'b0) begin n_fail++; $display("FAIL w7_rst_ferr: got %b need 0", fe7); end
    cycles(40);
    send_frame(1, 7, 9'($urandom), 15, 1, 1'($urandom), 0, 0, 1, 1);
    cycles(40);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL w7_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] w7: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL w7_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int cpb;
    bit s2;
    for (int k = 0; k < 10; k++) begin
      cpb = $urandom_range(4, 24);
      s2  = 1'($urandom);
      send_frame(0, 8, 9'($urandom), cpb, 1'($urandom), 1'($urandom), 1'($urandom), s2,
                 s2 ? 1'($urandom) : 1'b1, 1'b1);
      cycles($urandom_range(0, cpb));
    end
    cycles(60);
    n_run++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d pulses need %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_run++;
      $display("[TB] random: unit=%0d at=%0d data=%h perr=%b ferr=%b", g.unit, g.at, g.data, g.perr, g.ferr);
      if (g !== e) begin
        n_fail++;
        $display("FAIL random_frame: got at=%0d data=%h perr=%b ferr=%b need at=%0d data=%h perr=%b ferr=%b",
                 g.at, g.data, g.perr, g.ferr, e.at, e.data, e.perr, e.ferr);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_width7();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
